h6_mul_sequencer: RTL
=====================

# h6_mul_sequencer

Control sequencer for the H6 multiplier wrapper in the ALU datapath. On a single `start` it clears the H6, loads the multiplicand from the A bus and the multiplier from the B bus, and issues the iteration strobes. It then drives the A-register and Q-register results onto the S-bus in two consecutive cycles and latches the carry and overflow flags. It sits between the main control unit and the H6 wrapper, and owns every H6 control input.

## Interface
Parameters:
- `STEPS`, 16: multiply iterations, i.e. `inQLK` pulses. Legal range 1–63.
- `CLR_CYCLES`, 2: cycles `h6_rst` is held high at sequence start. Legal range 1–7.

Ports:
- `CLK_50`  in  1  clock; all state changes on the rising edge.
- `Rst_n`  in  1  asynchronous active-low reset.
- `start`  in  1  request pulse; sampled only in IDLE.
- `b_sel`  in  1  multiplier source; latched at start. 0 selects `MUL2_1`, 1 selects `MUL2_2`.
- `abort`  in  1  cancel request; only active under `H6_SEQ_ABORT_EN`.
- `alu_carryOut`  in  1  H6 carry flag.
- `alu_overflowOut`  in  1  H6 overflow flag.
- `MUL1`, `MUL2_1`, `MUL2_2`  out  1 each  H6 input-gate enables.
- `h6_rst`  out  1  drives H6 `Rst`.
- `inQLK`, `inTWO`, `inTHREE`, `inFOUR`  out  1 each  H6 control strobes.
- `ALS_H6_a`, `ALS_H6_q`  out  1 each  S-bus output enables.
- `busy`  out  1  sequence in progress.
- `done`  out  1  one-cycle completion pulse.
- `carry_q`, `ovf_q`  out  1 each  latched result flags.

## Operation
- All outputs are registered, with no combinational paths from inputs to outputs.
- States: IDLE, CLR, LDA, LDB, STEP, OUTA, OUTQ, DONE.
- IDLE: all strobes are low. `start`=1 latches `b_sel` and moves to CLR.
- CLR: `h6_rst`=1 for `CLR_CYCLES` cycles, then LDA.
- LDA: `MUL1`=1 and `inTWO`=1 for one cycle, then LDB.
- LDB: `inTHREE`=1 for one cycle, together with `MUL2_1` or `MUL2_2` according to the latched `b_sel`. Then STEP.
- STEP: lasts 2×`STEPS` cycles.
  - `inQLK`=1 on the first cycle of each pair and 0 on the second.
  - A 6-bit step counter increments on each high phase.
  - After the last low phase the state moves to OUTA.
- OUTA: `ALS_H6_a`=1 and `inFOUR`=1 for one cycle.
- OUTQ: `ALS_H6_q`=1 and `inFOUR`=1 for one cycle. `carry_q`/`ovf_q` capture `alu_carryOut`/`alu_overflowOut` at the end of this cycle.
- DONE: `done`=1 for one cycle, then IDLE.
- `busy`=1 in every state except IDLE and DONE.
- At most one of `MUL1`/`MUL2_1`/`MUL2_2` is high in any cycle. `ALS_H6_a` and `ALS_H6_q` are never high together.
- `start` is ignored outside IDLE. There is no queuing, so a start arriving in DONE is dropped.
- `carry_q`/`ovf_q` hold their values until the next OUTQ capture. They are not cleared by `start`.

## Timing
- Reset (`Rst_n`=0, asynchronous):
  - state goes to IDLE;
  - every output is 0, including `carry_q`, `ovf_q`, `busy`, `done`;
  - the step counter is 0.
- Reset mid-sequence aborts immediately. No S-bus enable may remain high after reset.
- With `start` sampled at edge 0 and default parameters:
  - cycles 1–2: CLR;
  - cycle 3: LDA;
  - cycle 4: LDB;
  - cycles 5–36: STEP, with `inQLK` high on cycles 5, 7, …, 35;
  - cycle 37: OUTA;
  - cycle 38: OUTQ;
  - cycle 39: DONE;
  - cycle 40: IDLE, where a new `start` is accepted.
- General latency from the start edge to the `done` cycle is `CLR_CYCLES` + 2×`STEPS` + 5 cycles.
- `busy` rises in cycle 1 and falls at the start of cycle 39. `busy` and `done` are never high together.

## Configuration
- `H6_SEQ_ABORT_EN` defined:
  - `abort`=1 sampled in any state from CLR through OUTQ forces, on the next cycle, one CLR cycle with `h6_rst`=1 and all other strobes 0, followed by IDLE.
  - `done` is not pulsed and `carry_q`/`ovf_q` are unchanged.
  - `abort` in IDLE or DONE is ignored.
- `H6_SEQ_ABORT_EN` undefined: `abort` is unconnected internally and has no effect. Sequences always run to DONE.

## Test plan
- Reset check: hold `Rst_n`=0, then release. All outputs are 0. `start` in the first cycle after release begins CLR at the next cycle.
- Nominal run, defaults, `b_sel`=0: the strobe pattern matches the cycle map exactly. `inQLK` has exactly 16 high cycles, `MUL2_2` is never high, and `done` pulses in cycle 39.
- Run with `b_sel`=1, and `alu_carryOut`=1, `alu_overflowOut`=0 during OUTQ: `MUL2_2` is high only in cycle 4, `MUL2_1` is never high, and after DONE `carry_q`=1, `ovf_q`=0.
- Start storm: hold `start` high for 45 cycles. Exactly two sequences run, the second starting at edge 40. `start` in DONE is not accepted.
- Mid-run reset: pull `Rst_n` low in cycle 37 (OUTA). `ALS_H6_a` drops to 0 asynchronously, and `done` never pulses.
- Abort (`H6_SEQ_ABORT_EN` defined): `abort`=1 in cycle 20 gives `h6_rst`=1 in cycle 21 and IDLE in cycle 22. `busy` is 0 from cycle 22, and there is no `done` pulse.

Source files
------------

// File: rtl/h6_mul_sequencer.sv
// Control sequencer for the H6 multiplier: clear, load A/B, iterate, drive S-bus, latch flags.
// Optional cancel path is compiled in with `define H6_SEQ_ABORT_EN.
module h6_mul_sequencer #(
  parameter int STEPS      = 16,
  parameter int CLR_CYCLES = 2
) (
  input  logic CLK_50,
  input  logic Rst_n,
  input  logic start,
  input  logic b_sel,
  input  logic abort,
  input  logic alu_carryOut,
  input  logic alu_overflowOut,
  output logic MUL1,
  output logic MUL2_1,
  output logic MUL2_2,
  output logic h6_rst,
  output logic inQLK,
  output logic inTWO,
  output logic inTHREE,
  output logic inFOUR,
  output logic ALS_H6_a,
  output logic ALS_H6_q,
  output logic busy,
  output logic done,
  output logic carry_q,
  output logic ovf_q
);

  typedef enum logic [2:0] {
    S_IDLE, S_CLR, S_LDA, S_LDB, S_STEP, S_OUTA, S_OUTQ, S_DONE
  } state_t;

  localparam logic [2:0] CLR_LAST  = 3'(CLR_CYCLES - 1);
  localparam logic [5:0] STEP_LAST = 6'(STEPS);

  state_t     state, state_nxt;
  logic [2:0] clr_cnt;
  logic [5:0] step_cnt;
  logic       phase;
  logic       b_sel_q;
  logic       abort_clr;
  logic       abort_req;

  logic mul1_nxt, mul2_1_nxt, mul2_2_nxt, h6_rst_nxt, inqlk_nxt, intwo_nxt;
  logic inthree_nxt, infour_nxt, als_a_nxt, als_q_nxt, busy_nxt, done_nxt;

`ifdef H6_SEQ_ABORT_EN
  assign abort_req = abort && (state != S_IDLE) && (state != S_DONE);
`else
  logic unused_abort;
  assign unused_abort = abort;
  assign abort_req    = 1'b0;
`endif

  // State, counters, flags and the registered copies of every output.
  always_ff @(posedge CLK_50 or negedge Rst_n) begin
    if (!Rst_n) begin
      state     <= S_IDLE;
      clr_cnt   <= '0;
      step_cnt  <= '0;
      phase     <= 1'b0;
      b_sel_q   <= 1'b0;
      abort_clr <= 1'b0;
      carry_q   <= 1'b0;
      ovf_q     <= 1'b0;
      MUL1      <= 1'b0;
      MUL2_1    <= 1'b0;
      MUL2_2    <= 1'b0;
      h6_rst    <= 1'b0;
      inQLK     <= 1'b0;
      inTWO     <= 1'b0;
      inTHREE   <= 1'b0;
      inFOUR    <= 1'b0;
      ALS_H6_a  <= 1'b0;
      ALS_H6_q  <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      state     <= state_nxt;
      clr_cnt   <= (state == S_CLR && state_nxt == S_CLR) ? clr_cnt + 3'd1 : 3'd0;
      phase     <= (state == S_STEP) ? ~phase : 1'b0;
      abort_clr <= abort_req || (abort_clr && state_nxt == S_CLR);
      if (state == S_STEP && !phase)
        step_cnt <= step_cnt + 6'd1;
      else if (state != S_STEP)
        step_cnt <= '0;
      if (state == S_IDLE && start)
        b_sel_q <= b_sel;
      if (state == S_OUTQ && !abort_req) begin
        carry_q <= alu_carryOut;
        ovf_q   <= alu_overflowOut;
      end
      MUL1     <= mul1_nxt;
      MUL2_1   <= mul2_1_nxt;
      MUL2_2   <= mul2_2_nxt;
      h6_rst   <= h6_rst_nxt;
      inQLK    <= inqlk_nxt;
      inTWO    <= intwo_nxt;
      inTHREE  <= inthree_nxt;
      inFOUR   <= infour_nxt;
      ALS_H6_a <= als_a_nxt;
      ALS_H6_q <= als_q_nxt;
      busy     <= busy_nxt;
      done     <= done_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    if (abort_req) begin
      state_nxt = S_CLR;
    end else begin
      case (state)
        S_IDLE: if (start) state_nxt = S_CLR;
        S_CLR: begin
          if (abort_clr)                  state_nxt = S_IDLE;
          else if (clr_cnt == CLR_LAST)   state_nxt = S_LDA;
        end
        S_LDA:  state_nxt = S_LDB;
        S_LDB:  state_nxt = S_STEP;
        S_STEP: if (phase && step_cnt == STEP_LAST) state_nxt = S_OUTA;
        S_OUTA: state_nxt = S_OUTQ;
        S_OUTQ: state_nxt = S_DONE;
        S_DONE: state_nxt = S_IDLE;
        default: state_nxt = S_IDLE;
      endcase
    end
  end

  // Outputs are decoded from the next state so they line up with it once registered.
  always_comb begin
    mul1_nxt    = (state_nxt == S_LDA);
    intwo_nxt   = (state_nxt == S_LDA);
    inthree_nxt = (state_nxt == S_LDB);
    mul2_1_nxt  = (state_nxt == S_LDB) && !b_sel_q;
    mul2_2_nxt  = (state_nxt == S_LDB) &&  b_sel_q;
    h6_rst_nxt  = (state_nxt == S_CLR);
    inqlk_nxt   = (state_nxt == S_STEP) && (state != S_STEP || phase);
    als_a_nxt   = (state_nxt == S_OUTA);
    als_q_nxt   = (state_nxt == S_OUTQ);
    infour_nxt  = (state_nxt == S_OUTA) || (state_nxt == S_OUTQ);
    busy_nxt    = (state_nxt != S_IDLE) && (state_nxt != S_DONE);
    done_nxt    = (state_nxt == S_DONE);
  end

endmodule
